// File: rtl/audio_pkg.sv
// Shared audio-path constants and the wave-capture state encoding.
// Pure declarations: no latency, no flow control.
package audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 16;
    localparam int WC_ADDR_WIDTH      = 8;
    localparam int WC_STORE_WIDTH     = 8;

    typedef enum logic [1:0] {
        WC_ARMED  = 2'd0,
        WC_ACTIVE = 2'd1,
        WC_WAIT   = 2'd2
    } wc_state_t;

endpackage

// File: rtl/zero_cross_detector.sv
// Flags a negative-to-non-negative sample transition; combinational, same cycle as the strobe.
// No backpressure: previous-sample state advances on every strobe.
module zero_cross_detector (
    input  logic clk,
    input  logic reset,
    input  logic new_sample_ready,
    input  logic new_sample_sign,
    output logic rising_cross
);

    // Only the sign of the previous sample is ever consulted, so only it is kept.
    logic prev_sign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sign_q <= 1'b0;
        end else if (new_sample_ready) begin
            prev_sign_q <= new_sample_sign;
        end
    end

    assign rising_cross = new_sample_ready && prev_sign_q && !new_sample_sign;

endmodule

// File: rtl/wave_capture.sv
// Triggered capture of 2^ADDR_WIDTH samples into the hidden half of a ping-pong RAM; writes land 1 cycle after the strobe.
// No backpressure: the stream is never stalled, samples outside a capture are simply dropped.
module wave_capture
    import audio_pkg::*;
#(
    parameter int ADDR_WIDTH   = WC_ADDR_WIDTH,
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int STORE_WIDTH  = WC_STORE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    output logic [ADDR_WIDTH:0]     write_address,
    output logic                    write_enable,
    output logic [STORE_WIDTH-1:0]  write_sample,
    output logic                    read_index,
    output logic                    capture_done
);

    wc_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   index_q, index_d;
    logic                    read_index_q, read_index_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH:0]     wr_addr_q, wr_addr_d;
    logic [STORE_WIDTH-1:0]  wr_sample_q, wr_sample_d;
    logic                    done_q, done_d;
    logic                    rising_cross;
    logic [STORE_WIDTH-1:0]  stored_sample;
    logic                    unused_low_bits;

    zero_cross_detector u_zero_cross (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_sign  (new_sample_in[SAMPLE_WIDTH-1]),
        .rising_cross     (rising_cross)
    );

    // Offset binary: flip the sign bit of the top STORE_WIDTH bits.
    assign stored_sample   = {~new_sample_in[SAMPLE_WIDTH-1],
                              new_sample_in[SAMPLE_WIDTH-2:SAMPLE_WIDTH-STORE_WIDTH]};
    assign unused_low_bits = ^new_sample_in[SAMPLE_WIDTH-STORE_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        read_index_d = read_index_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_sample_d  = wr_sample_q;
        done_d       = 1'b0;

        unique case (state_q)
            WC_ARMED: begin
                if (rising_cross) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = {~read_index_q, {ADDR_WIDTH{1'b0}}};
                    wr_sample_d = stored_sample;
                    index_d     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    state_d     = WC_ACTIVE;
                end
            end
            WC_ACTIVE: begin
                if (new_sample_ready) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = {~read_index_q, index_q};
                    wr_sample_d = stored_sample;
                    index_d     = index_q + 1'b1;
                    if (index_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = WC_WAIT;
                    end
                end
            end
            WC_WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    done_d       = 1'b1;
                    state_d      = WC_ARMED;
                end
            end
            default: begin
                state_d = WC_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WC_ARMED;
            index_q      <= '0;
            read_index_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_sample_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            read_index_q <= read_index_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_sample_q  <= wr_sample_d;
            done_q       <= done_d;
        end
    end

    assign write_enable  = wr_en_q;
    assign write_address = wr_addr_q;
    assign write_sample  = wr_sample_q;
    assign read_index    = read_index_q;
    assign capture_done  = done_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture: vector table plus multi-cycle capture sequences.
module tb_wave_capture;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        capture_done;

    int checks = 0;
    int errors = 0;

    wave_capture dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index),
        .capture_done      (capture_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [15:0] smp;
        logic        idl;
        logic        we;
        logic [8:0]  addr;
        logic [7:0]  ws;
        logic        ri;
        logic        done;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge take them, look 1 time unit later.
    task automatic step(input logic rdy, input logic [15:0] s, input logic idl);
        new_sample_ready  = rdy;
        new_sample_in     = s;
        wave_display_idle = idl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string name, input logic we, input logic [8:0] addr,
                               input logic [7:0] ws, input logic ri, input logic done);
        check({name, ".ctl"}, {29'd0, write_enable, read_index, capture_done}, {29'd0, we, ri, done});
        if (we) begin
            check({name, ".addr"}, {23'd0, write_address}, {23'd0, addr});
            check({name, ".smp"},  {24'd0, write_sample},  {24'd0, ws});
        end
    endtask

    // Feeds n ramp samples in ACTIVE, expecting consecutive writes from first_addr upward.
    task automatic run_ramp(input string name, input int n, input logic [8:0] first_addr,
                            input logic ri, output int writes);
        logic [15:0] s;
        writes = 0;
        for (int k = 0; k < n; k++) begin
            s = 16'((k + 3) << 8);
            step(1'b1, s, 1'b0);
            check_cycle(name, 1'b1, 9'(first_addr + 9'(k)), s[15:8] ^ 8'h80, ri, 1'b0);
            if (write_enable) writes++;
        end
    endtask

    initial begin
        int          wr_count;
        int          n;
        logic [15:0] s;
        logic [7:0]  ws;

        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;
        reset             = 1'b0;

        for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 16'h1000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'hF000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 16'h0000, 1'b0, 1'b1, 9'h100, 8'h80, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 16'h7FFF, 1'b1, 1'b1, 9'h101, 8'hFF, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 16'h8000, 1'b0, 1'b1, 9'h102, 8'h00, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 16'h1234, 1'b0, 1'b1, 9'h103, 8'h92, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset.outs", {19'd0, write_enable, write_address, write_sample, read_index, capture_done}, 32'd0);
        reset = 1'b1;

        // Idle, trigger, first writes, idle ignored while ACTIVE.
        wr_count = 0;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rdy, tbl[i].smp, tbl[i].idl);
            check_cycle($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].ws, tbl[i].ri, tbl[i].done);
            if (write_enable) wr_count++;
        end

        // Rest of capture 1 (idle held high for part of it), then samples in WAIT.
        for (int i = 0; i < 300; i++) begin
            s  = 16'(i << 8);
            ws = s[15:8] ^ 8'h80;
            step(1'b1, s, i < 50);
            check_cycle("cap1", i < 252, 9'(9'h104 + 9'(i)), ws, 1'b0, 1'b0);
            if (write_enable) wr_count++;
        end
        check("cap1.count", 32'(wr_count), 32'd256);

        // Swap.
        step(1'b0, 16'h0000, 1'b1);
        check_cycle("swap1", 1'b0, 9'h0, 8'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        check_cycle("swap1.after", 1'b0, 9'h0, 8'h0, 1'b1, 1'b0);

        // Capture 2 lands in the lower half.
        step(1'b1, 16'h8000, 1'b0);
        check_cycle("cap2.neg", 1'b0, 9'h0, 8'h0, 1'b1, 1'b0);
        step(1'b1, 16'h0100, 1'b0);
        check_cycle("cap2.trig", 1'b1, 9'h000, 8'h81, 1'b1, 1'b0);
        run_ramp("cap2", 255, 9'h001, 1'b1, n);
        check("cap2.count", 32'(n + 1), 32'd256);

        // Idle coincident with a would-be trigger in WAIT: swap only.
        step(1'b1, 16'h8000, 1'b0);
        check_cycle("wait.smp", 1'b0, 9'h0, 8'h0, 1'b1, 1'b0);
        step(1'b1, 16'h0100, 1'b1);
        check_cycle("coinc.swap", 1'b0, 9'h0, 8'h0, 1'b0, 1'b1);
        step(1'b1, 16'h0200, 1'b0);
        check_cycle("coinc.notrig", 1'b0, 9'h0, 8'h0, 1'b0, 1'b0);

        // Capture 3 back in the upper half, then swap again.
        step(1'b1, 16'hF000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        check_cycle("cap3.trig", 1'b1, 9'h100, 8'h80, 1'b0, 1'b0);
        run_ramp("cap3", 255, 9'h101, 1'b0, n);
        step(1'b0, 16'h0000, 1'b1);
        check_cycle("swap3", 1'b0, 9'h0, 8'h0, 1'b1, 1'b1);

        // Capture 4: abandon after 100 writes with an async reset.
        step(1'b1, 16'hF000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        check_cycle("cap4.trig", 1'b1, 9'h000, 8'h80, 1'b1, 1'b0);
        run_ramp("cap4", 99, 9'h001, 1'b1, n);
        check("cap4.count", 32'(n + 1), 32'd100);
        reset = 1'b0;
        #1;
        check("rst.async", {30'd0, write_enable, read_index}, 32'd0);
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        check("rst.held", {19'd0, write_enable, write_address, write_sample, read_index, capture_done}, 32'd0);
        reset = 1'b1;
        step(1'b1, 16'hF000, 1'b0);
        check_cycle("post.neg", 1'b0, 9'h0, 8'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        check_cycle("post.trig", 1'b1, 9'h100, 8'h80, 1'b0, 1'b0);
        step(1'b1, 16'h4000, 1'b0);
        check_cycle("post.idx1", 1'b1, 9'h101, 8'hC0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        check_cycle("post.pulse", 1'b0, 9'h0, 8'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Downstream consumer of the music player's sample stream (new_sample_generated / sample_out).
- Waits for a rising zero crossing, then captures 2^ADDR_WIDTH consecutive samples as 8-bit offset-binary values into one half of a ping-pong display RAM.
- Then waits for the wave display to go idle and swaps halves.
- Feeds the wave display's RAM write port and tells the display which half to read.

Parameters:
- ADDR_WIDTH, 8: log2 of samples per capture (256).
- SAMPLE_WIDTH, 16: width of incoming signed sample.
- STORE_WIDTH, 8: width of stored sample; top STORE_WIDTH bits of the input.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- new_sample_ready  input  1  one-cycle strobe: new_sample_in valid this cycle
- new_sample_in  input  SAMPLE_WIDTH  signed two's-complement sample
- wave_display_idle  input  1  display is between frames, safe to swap
- write_address  output  ADDR_WIDTH+1  {buffer select, index}
- write_enable  output  1  one-cycle RAM write strobe
- write_sample  output  STORE_WIDTH  offset-binary stored sample
- read_index  output  1  half the display must read
- capture_done  output  1  one-cycle pulse on buffer swap

Behaviour:
- Reset (reset==0, async):
  - state=ARMED; index=0; prev_sample=0; read_index=0.
  - write_enable=0; write_address=0; write_sample=0; capture_done=0.
  - Reset mid-capture abandons the partial buffer; no further writes occur.
- prev_sample register:
  - Loads new_sample_in on every new_sample_ready, in every state.
- Conversion: write_sample = {~s[SW-1], s[SW-2 : SW-STORE_WIDTH]}, where s = new_sample_in. This is an MSB flip, so 0x8000->0x00, 0x0000->0x80, 0x7FFF->0xFF.
- Write buffer is always the non-displayed half. write_address = {~read_index, index}.
- Write latency: write_enable, write_address and write_sample are registered. They are valid exactly one cycle after the accepting new_sample_ready, and write_enable is high for one cycle only.
- FSM states: ARMED, ACTIVE, WAIT (encodings in package).
  - ARMED:
    - Trigger when new_sample_ready && prev_sample[SW-1]==1 && new_sample_in[SW-1]==0. 0x0000 counts as non-negative.
    - On trigger: write the triggering sample at index 0, set index=1, go to ACTIVE.
    - With no trigger, nothing is written.
  - ACTIVE:
    - Each new_sample_ready writes at index, then index++.
    - When the write is at index 2^ADDR_WIDTH-1, index wraps to 0 and the state goes to WAIT.
    - Exactly 2^ADDR_WIDTH writes occur per capture.
  - WAIT:
    - Samples are ignored (no writes); prev_sample still updates.
    - When wave_display_idle==1: toggle read_index, pulse capture_done for 1 cycle (registered, the next cycle), go to ARMED.
- Simultaneous events:
  - wave_display_idle is sampled only in WAIT. Idle asserted during ARMED or ACTIVE has no effect.
  - If new_sample_ready and wave_display_idle coincide in WAIT: swap happens and the sample only updates prev_sample. The earliest possible trigger is the next sample.
  - Last ACTIVE write and wave_display_idle in the same cycle: go to WAIT only; the swap needs idle in a later cycle.
- new_sample_ready held high for consecutive cycles: each cycle is a distinct sample.

Decomposition:
- Shared package (audio_pkg):
  - state encodings WC_ARMED=2'd0, WC_ACTIVE=2'd1, WC_WAIT=2'd2
  - default ADDR_WIDTH/STORE_WIDTH constants
  - SAMPLE_WIDTH=16, shared with the music player path
- One natural sub-module: zero_cross_detector. It holds prev_sample and produces a combinational rising_cross flag qualified by new_sample_ready.
- FSM, index counter and output registers stay in wave_capture.

Test Plan:
- Reset/idle:
  - Stimulus: hold reset=0, then release; feed 10 positive samples (0x1000).
  - Required: all outputs 0, no write_enable, state remains ARMED.
- Trigger plus first write:
  - Stimulus: samples 0xF000 then 0x0000.
  - Required: one cycle after the second strobe, write_enable=1, write_address=0x100, write_sample=0x80.
- Full capture:
  - Stimulus: after trigger, feed 300 strobes of a ramp.
  - Required: exactly 256 writes at addresses 0x100..0x1FF in order; no writes after the 256th; state WAIT.
- Swap:
  - Stimulus: in WAIT, assert wave_display_idle for 1 cycle.
  - Required: read_index 0->1, capture_done pulse 1 cycle.
  - Then: next negative->positive crossing writes at 0x000..0x0FF.
- Ignored idle/samples:
  - Stimulus: idle held high during ACTIVE.
  - Required: no swap.
  - Stimulus: samples in WAIT.
  - Required: no write_enable.
  - Stimulus: idle coincident with strobe of 0x0100 after prev 0x8000.
  - Required: swap, no trigger on that sample.
- Reset mid-capture:
  - Stimulus: assert reset after 100 writes.
  - Required: write_enable drops immediately (async), read_index=0, index=0.
  - Then: next capture starts at 0x100.
